jk_cmd_seq: RTL

//  Upstream command sequencer for a bank of WIDTH positive-edge JK flip-flops.

---
 rtl/jk_cmd_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: command sequencer for a bank of WIDTH JK flip-flops.
//   Buffers {J,K,rep} commands in a DEPTH-entry FIFO, drives each command's
//   J/K for rep+1 cycles (back-to-back when more are queued, otherwise J=K=0),
//   and keeps a shadow model q_exp of the flop bank's Q.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        command handshake (push = in_valid & in_ready)
//   in_j, in_k, in_rep       command payload
//   J, K                     registered drive to the flop bank
//   busy                     1 while a command is being driven
//   q_exp                    expected Q of the flop bank
//   count                    FIFO occupancy, 0..DEPTH
module jk_cmd_seq #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_j,
   input  logic [WIDTH-1:0]         in_k,
   input  logic [CNT_W-1:0]         in_rep,
   output logic [WIDTH-1:0]         J,
   output logic [WIDTH-1:0]         K,
   output logic                     busy,
   output logic [WIDTH-1:0]         q_exp,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned OCC_W  = PTR_W + 1;
   localparam int unsigned ENT_W  = 2 * WIDTH + CNT_W;

   typedef enum logic {IDLE, DRIVE} state_t;

   state_t              state_q;
   logic [WIDTH-1:0]    j_q, k_q, q_exp_q;
   logic [CNT_W-1:0]    rem_q;
   logic                busy_q;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0]    count_q, count_d;
   logic [ENT_W-1:0]    mem_q [DEPTH];

   logic                full, empty, push, pop;
   logic [WIDTH-1:0]    head_j, head_k, q_exp_d;
   logic [CNT_W-1:0]    head_rep;

   // Handshake, pop decision and shadow-model next value
   always_comb begin
      full     = (count_q == OCC_W'(DEPTH));
      empty    = (count_q == '0);
      in_ready = ~full & ~rst;
      push     = in_valid & in_ready;
      // A new command is taken from IDLE, or when the current one has run out
      pop      = ~empty & ((state_q == IDLE) | (rem_q == '0));
      {head_j, head_k, head_rep} = mem_q[rd_ptr_q];
      count_d  = count_q + OCC_W'(push) - OCC_W'(pop);
      // Per bit: 00 hold, 01 clear, 10 set, 11 toggle
      q_exp_d  = (j_q & ~q_exp_q) | (~k_q & q_exp_q);
   end

   // FIFO storage (no reset needed: only entries behind the write pointer are read)
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_j, in_k, in_rep};
   end

   // FIFO pointers, occupancy, shadow model and drive FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         j_q      <= '0;
         k_q      <= '0;
         rem_q    <= '0;
         busy_q   <= 1'b0;
         q_exp_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         q_exp_q <= q_exp_d;

         case (state_q)
            IDLE: begin
               if (pop) begin
                  j_q     <= head_j;
                  k_q     <= head_k;
                  rem_q   <= head_rep;
                  busy_q  <= 1'b1;
                  state_q <= DRIVE;
               end
            end
            DRIVE: begin
               if (rem_q != '0) begin
                  rem_q <= rem_q - CNT_W'(1);
               end else if (pop) begin
                  j_q   <= head_j;
                  k_q   <= head_k;
                  rem_q <= head_rep;
               end else begin
                  j_q     <= '0;
                  k_q     <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign J     = j_q;
   assign K     = k_q;
   assign busy  = busy_q;
   assign q_exp = q_exp_q;
   assign count = count_q;

endmodule
